pwm_demod: RTL and testbench

PWM_DEMOD -- requirements
Module: pwm_demod

---
 rtl/pwm_demod.sv | 130 +++++++++++++
 tb/tb_pwm_demod.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_demod.sv
// pwm_demod: recovers a signed speed value from the duty cycle of a PWM
// pair. PWM1 carries the measurement; PWM2 is only watched for overlap with
// PWM1 (shoot-through). A missing PWM1 edge for TMO cycles produces a
// saturated report so downstream logic never sees a stale speed forever.
module pwm_demod #(
  parameter int PERIOD = 2048,
  parameter int TMO    = 4095
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PWM1,
  input  logic               PWM2,
  input  logic               clr_err,
  output logic signed [10:0] spd,
  output logic        [11:0] per,
  output logic               vld,
  output logic               sat,
  output logic               shoot
);

  // Offset that maps a half-duty frame to zero speed.
  localparam logic [11:0] HALF  = 12'(PERIOD / 2);
  localparam logic [11:0] TMO_C = 12'(TMO);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t      state;
  logic        p1_p0, p1s, p1d;
  logic        p2_p0, p2s;
  logic [11:0] per_cnt;
  logic [10:0] hi_cnt;
  logic        rise;

  // Saturating increment of the frame-length counter.
  function automatic logic [11:0] inc_per(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  // Saturating increment of the high-time counter.
  function automatic logic [10:0] inc_hi(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  // High count minus the half-frame offset, wrapped to 11 bits.
  function automatic logic signed [10:0] centre(input logic [10:0] h);
    return signed'(h - HALF[10:0]);
  endfunction

  assign rise = p1s & ~p1d;

  // Two-flop synchronizers for both phases plus the edge-detect history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_p0 <= 1'b0;
      p1s   <= 1'b0;
      p1d   <= 1'b0;
      p2_p0 <= 1'b0;
      p2s   <= 1'b0;
    end else begin
      p1_p0 <= PWM1;
      p1s   <= p1_p0;
      p1d   <= p1s;
      p2_p0 <= PWM2;
      p2s   <= p2_p0;
    end
  end

  // Frame measurement FSM with registered report outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      per_cnt <= '0;
      hi_cnt  <= '0;
      spd     <= '0;
      per     <= '0;
      vld     <= 1'b0;
      sat     <= 1'b0;
    end else begin
      vld <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state   <= MEAS;
            per_cnt <= 12'd1;
            hi_cnt  <= 11'd1;
          end else begin
            per_cnt <= '0;
            hi_cnt  <= '0;
          end
        end
        MEAS: begin
          if (rise) begin
            // A real edge always wins over a coincident timeout.
            spd     <= centre(hi_cnt);
            per     <= per_cnt;
            sat     <= 1'b0;
            vld     <= 1'b1;
            per_cnt <= 12'd1;
            hi_cnt  <= 11'd1;
          end else if (per_cnt == TMO_C) begin
            spd     <= p1s ? 11'sh3FF : 11'sh400;
            per     <= TMO_C;
            sat     <= 1'b1;
            vld     <= 1'b1;
            per_cnt <= 12'd1;
            hi_cnt  <= {10'd0, p1s};
          end else begin
            per_cnt <= inc_per(per_cnt);
            if (p1s) begin
              hi_cnt <= inc_hi(hi_cnt);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky shoot-through flag; a new overlap beats a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shoot <= 1'b0;
    end else if (p1s && p2s) begin
      shoot <= 1'b1;
    end else if (clr_err) begin
      shoot <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pwm_demod.sv
// Bench for pwm_demod: a cycle-indexed history model predicts every output
// each clock; directed frames pin the headline values with literals.
module tb_pwm_demod;
  localparam int TMO  = 4095;
  localparam int HMAX = 131072;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic PWM1 = 1'b0;
  logic PWM2 = 1'b0;
  logic clr_err = 1'b0;
  logic signed [10:0] spd;
  logic [11:0] per;
  logic vld, sat, shoot;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_demod #(.PERIOD(2048), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .PWM1(PWM1), .PWM2(PWM2), .clr_err(clr_err),
    .spd(spd), .per(per), .vld(vld), .sat(sat), .shoot(shoot)
  );

  // Pin values as seen at each clock edge; synchronized view lags by two.
  bit h1 [0:HMAX-1];
  bit h2 [0:HMAX-1];
  int cyc = 3;

  bit          m_meas = 1'b0;
  int          m_anchor = 0;
  logic [10:0] e_spd = '0;
  logic [11:0] e_per = '0;
  bit          e_vld = 1'b0, e_sat = 1'b0, e_shoot = 1'b0;

  int          dut_vlds = 0;
  logic [10:0] d_spd = '0;
  logic [11:0] d_per = '0;
  logic        d_sat = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model and per-cycle comparison.
  always @(posedge clk) begin
    bit o, op, o2;
    int hi;
    if (cyc < HMAX) begin
      if (!rst_n) begin
        h1[cyc] = 1'b0; h1[cyc-1] = 1'b0; h1[cyc-2] = 1'b0;
        h2[cyc] = 1'b0; h2[cyc-1] = 1'b0; h2[cyc-2] = 1'b0;
        m_meas = 1'b0;
        e_spd = '0; e_per = '0; e_vld = 1'b0; e_sat = 1'b0; e_shoot = 1'b0;
      end else begin
        h1[cyc] = PWM1;
        h2[cyc] = PWM2;
        o  = h1[cyc-2];
        op = h1[cyc-3];
        o2 = h2[cyc-2];
        e_vld = 1'b0;
        if (!m_meas) begin
          if (o && !op) begin
            m_meas = 1'b1;
            m_anchor = cyc;
          end
        end else if (o && !op) begin
          hi = 0;
          for (int k = m_anchor; k < cyc; k++) hi += int'(h1[k-2]);
          if (hi > 2047) hi = 2047;
          e_spd = 11'(hi - 1024);
          e_per = 12'(((cyc - m_anchor) > 4095) ? 4095 : (cyc - m_anchor));
          e_sat = 1'b0;
          e_vld = 1'b1;
          m_anchor = cyc;
        end else if (cyc - m_anchor == TMO) begin
          e_spd = o ? 11'h3FF : 11'h400;
          e_per = 12'(TMO);
          e_sat = 1'b1;
          e_vld = 1'b1;
          m_anchor = cyc;
        end
        e_shoot = (o && o2) ? 1'b1 : (clr_err ? 1'b0 : e_shoot);
      end
      cyc++;
    end
    #1;
    chk("vld", {31'd0, vld}, {31'd0, e_vld});
    chk("spd", {21'd0, $unsigned(spd)}, {21'd0, e_spd});
    chk("per", {20'd0, per}, {20'd0, e_per});
    chk("sat", {31'd0, sat}, {31'd0, e_sat});
    chk("shoot", {31'd0, shoot}, {31'd0, e_shoot});
    if (vld === 1'b1) begin
      dut_vlds++;
      d_spd = spd;
      d_per = per;
      d_sat = sat;
    end
  end

  task automatic zero_outputs(input string tag);
    chk({tag, "_spd"}, {21'd0, $unsigned(spd)}, 32'd0);
    chk({tag, "_per"}, {20'd0, per}, 32'd0);
    chk({tag, "_vld"}, {31'd0, vld}, 32'd0);
    chk({tag, "_sat"}, {31'd0, sat}, 32'd0);
    chk({tag, "_shoot"}, {31'd0, shoot}, 32'd0);
  endtask

  task automatic last_rep(input string tag, input logic [10:0] s, input logic [11:0] p, input logic st);
    chk({tag, "_spd"}, {21'd0, d_spd}, {21'd0, s});
    chk({tag, "_per"}, {20'd0, d_per}, {20'd0, p});
    chk({tag, "_sat"}, {31'd0, d_sat}, {31'd0, st});
  endtask

  // One PWM frame: hi cycles high then low; optional mid-frame reset.
  task automatic frame(input int hi, input int len, input int rst_at = -1, input bit rnd = 1'b0);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      PWM1 = (i < hi);
      PWM2 = ~PWM1;
      if (rnd && $urandom_range(0, 199) == 0) PWM2 = 1'b1;
      clr_err = rnd && ($urandom_range(0, 299) == 0);
      if (i == rst_at + 1) rst_n = 1'b1;
      if (i == rst_at) begin
        #2 rst_n = 1'b0;
        #1 zero_outputs("async_rst");
      end
    end
  endtask

  initial begin
    int c;
    #1 zero_outputs("por");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    frame(0, 20);

    c = dut_vlds;
    repeat (5) frame(1024, 2048);
    chk("half_vld_count", 32'(dut_vlds - c), 32'd4);
    last_rep("half", 11'h000, 12'd2048, 1'b0);

    frame(1536, 2048);
    frame(1, 2048);
    last_rep("duty75", 11'h200, 12'd2048, 1'b0);
    frame(1024, 2048);
    last_rep("duty1", 11'h401, 12'd2048, 1'b0);

    c = dut_vlds;
    frame(1, 8500);
    chk("stuck_low_count", 32'(dut_vlds - c), 32'd3);
    last_rep("stuck_low", 11'h400, 12'd4095, 1'b1);
    frame(8500, 8500);
    last_rep("stuck_high", 11'h3FF, 12'd4095, 1'b1);
    frame(0, 10);

    frame(100, 4095);
    frame(100, 4095);
    frame(100, 2048);
    last_rep("edge_at_tmo", 11'h464, 12'd4095, 1'b0);

    frame(3000, 4000);
    frame(10, 2048);
    last_rep("hi_sat", 11'h3FF, 12'd4000, 1'b0);

    // Shoot-through: single overlap, clear, then overlap coincident with clear.
    chk("shoot_idle", {31'd0, shoot}, 32'd0);
    @(negedge clk); PWM1 = 1'b1; PWM2 = 1'b1;
    @(negedge clk); PWM1 = 1'b0; PWM2 = 1'b0;
    repeat (20) @(negedge clk);
    chk("shoot_set", {31'd0, shoot}, 32'd1);
    clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    chk("shoot_clr", {31'd0, shoot}, 32'd0);
    PWM1 = 1'b1; PWM2 = 1'b1;
    @(negedge clk); PWM1 = 1'b0; PWM2 = 1'b0;
    @(negedge clk); clr_err = 1'b1;
    @(negedge clk); clr_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("shoot_set_wins", {31'd0, shoot}, 32'd1);

    // Mid-frame reset discards the partial frame.
    frame(512, 2048, 700);
    c = dut_vlds;
    frame(512, 2048);
    chk("rst_no_report", 32'(dut_vlds - c), 32'd0);
    frame(512, 2048);
    chk("rst_one_report", 32'(dut_vlds - c), 32'd1);
    last_rep("after_rst", 11'h600, 12'd2048, 1'b0);

    for (int f = 0; f < 8; f++) begin
      int len;
      len = $urandom_range(300, 4500);
      frame($urandom_range(0, len), len, -1, 1'b1);
    end
    clr_err = 1'b0;
    frame(0, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
